dec16_serial: RTL and testbench
===============================

Name: dec16_serial

Overview:
Registered multi-cycle decrement unit for the ALU arithmetic group. It computes out = inp - 1 one DIGIT-wide slice per clock, using a ripple borrow chain held in a register. A start/busy/done handshake wraps the operation, and the unit reports borrow, zero and negative flags. It is the counterpart of the 16-bit increment unit and feeds the processor's decrement and loop-count (DJNZ-style) instructions.

Parameters:
WIDTH, 16, operand and result width in bits.
DIGIT, 4, bits processed per cycle. WIDTH must be an integer multiple of DIGIT.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
start  input  1  request a decrement of inp. Sampled only in IDLE.
inp  input  WIDTH  operand. Captured on the edge that accepts start.
busy  output  1  high in BUSY and DONE.
done  output  1  one-cycle pulse; out and flags are valid.
out  output  WIDTH  result = inp - 1 modulo 2^WIDTH. Held until the next completion.
borrow  output  1  final borrow out; high only when inp == 0.
zero  output  1  out == 0.
neg  output  1  out[WIDTH-1].

Behaviour:
- Define N = WIDTH/DIGIT (4 with the default parameters).
- Reset (rst low, asynchronous): state = IDLE; out = 0; borrow = 0; zero = 0; neg = 0; busy = 0; done = 0. Internal operand, result, digit index and borrow registers are cleared.
- Releasing reset mid-operation does not resume the operation. The unit restarts in IDLE with all outputs at their reset values.
- State IDLE:
  - start == 1 at an edge: capture inp into the operand register, set the borrow register to 1, set the digit index to 0, go to BUSY.
  - start == 0: stay in IDLE.
- State BUSY, at each edge, for digit index i from 0 to N-1:
  - d = operand[i*DIGIT +: DIGIT].
  - result slice i <= d - borrow_reg, modulo 2^DIGIT.
  - borrow_reg <= borrow_reg & (d == 0).
  - i <= i + 1.
  - There is no early exit: every operation takes a fixed N cycles, even when the borrow has died.
- Completion: the edge that processes digit N-1 also:
  - loads out with the complete result;
  - updates borrow, zero and neg from the final result and borrow;
  - moves the state to DONE.
- State DONE: done = 1 for exactly this one cycle. The next edge returns unconditionally to IDLE.
- Latency: start is sampled at edge 0; done is high in the cycle following edge N; out is valid from edge N onward.
- Throughput: start is accepted at most once every N+2 cycles. If start is held high continuously, it is accepted at edges 0, N+2, 2(N+2), and so on.
- start while busy: start in BUSY or DONE is ignored, not queued, and inp is not re-captured. Changes on inp after capture have no effect on the operation in flight.
- Output hold: out and the flags hold their previous values through IDLE and BUSY. They change only at the completion edge. busy is a direct decode of the state.
- Wrap-around: inp == 0 gives out = all-ones, borrow = 1, neg = 1, zero = 0.
- inp == 1 gives out = 0, zero = 1, borrow = 0.
- Arithmetic: unsigned. neg is the MSB of the result only; there is no separate signed-overflow flag.

Optional Feature:
Macro DEC_SATURATE_EN.
- Defined: underflow saturates. When inp == 0, the result is 0 instead of all-ones, with borrow = 1, zero = 1, neg = 0. This is applied at the completion edge using the final borrow. Latency is unchanged.
- Undefined: modular wrap as described in Behaviour, and no saturation logic is built.
- All other inputs give identical results in both builds.

Test Plan:
1. Reset low for 15 ns, then high; pulse start with inp = 0x000C. Required: busy is high for N+1 = 5 cycles; done pulses 4 edges after start is sampled; out = 0x000B, borrow = 0, zero = 0, neg = 0.
2. inp = 0x1000. Required: the borrow ripples across 3 digits; out = 0x0FFF, all flags 0.
3. inp = 0x0001. Required: out = 0x0000, zero = 1. Then inp = 0x8000. Required: out = 0x7FFF, neg = 0. Then inp = 0x0000. Required without the macro: out = 0xFFFF, borrow = 1, neg = 1. Required with DEC_SATURATE_EN: out = 0x0000, borrow = 1, zero = 1.
4. Start with 0x0010; pulse start again with inp = 0x5555 in BUSY cycle 2. Required: the second request is ignored; out = 0x000F; exactly one done pulse.
5. Start with 0x1234; drive rst low asynchronously (between clock edges) in BUSY cycle 2. Required: outputs are immediately 0 and state is IDLE; after release, done does not pulse until a new start arrives.
6. Hold start high with inp stepping 0x0003, 0x0002, 0x0001. Required: done pulses every 6 cycles; out sequence 0x0002, 0x0001, 0x0000; zero = 1 on the last result only.

Source files
------------

// File: rtl/dec16_serial.sv
// Multi-cycle decrement unit: out = inp - 1, one DIGIT-wide slice per clock.
// Optional build macro DEC_SATURATE_EN clamps an underflow (inp == 0) to zero.
module dec16_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             zero,
  output logic             neg,
  output logic [1:0]       dbg_state_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Handshake: start is sampled only in IDLE; the accepting edge captures inp.
  // busy stays high through BUSY and DONE; done is a one-cycle pulse and
  // marks the cycle in which out and the flags first show the new result.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic [31:0]      base;
  logic [DIGIT-1:0] dig;
  logic [DIGIT-1:0] slice;
  logic             brw_nx;
  logic             last;
  logic [WIDTH-1:0] full_res;
  logic [WIDTH-1:0] fin_res;

  // Datapath for the digit currently addressed by idx_q.
  always_comb begin
    base     = 32'(idx_q) * 32'(DIGIT);
    dig      = opnd_q[base +: DIGIT];
    slice    = dig - DIGIT'(brw_q);
    brw_nx   = brw_q & (dig == '0);
    last     = (idx_q == IW'(N - 1));
    full_res = res_q;
    full_res[base +: DIGIT] = slice;
`ifdef DEC_SATURATE_EN
    fin_res  = brw_nx ? '0 : full_res;
`else
    fin_res  = full_res;
`endif
  end

  always_comb begin
    state_d  = state_q;
    opnd_d   = opnd_q;
    res_d    = res_q;
    idx_d    = idx_q;
    brw_d    = brw_q;
    out_d    = out_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opnd_d  = inp;
          brw_d   = 1'b1;
          idx_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // No early exit: the borrow chain always walks all N digits.
        res_d = full_res;
        brw_d = brw_nx;
        idx_d = idx_q + IW'(1);
        if (last) begin
          out_d    = fin_res;
          borrow_d = brw_nx;
          zero_d   = (fin_res == '0);
          neg_d    = fin_res[WIDTH-1];
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      opnd_q   <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      brw_q    <= 1'b0;
      out_q    <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opnd_q   <= opnd_d;
      res_q    <= res_d;
      idx_q    <= idx_d;
      brw_q    <= brw_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign out         = out_q;
  assign borrow      = borrow_q;
  assign zero        = zero_q;
  assign neg         = neg_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dec16_serial.sv
// Bench for dec16_serial: directed vectors, a cycle-level behavioural model
// checked every cycle, plus hand-computed literal results.
module tb_dec16_serial;

  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] inp = '0;
  logic         busy, done, borrow, zero, neg;
  logic [W-1:0] out;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad = 0;

  dec16_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .inp         (inp),
    .busy        (busy),
    .done        (done),
    .out         (out),
    .borrow      (borrow),
    .zero        (zero),
    .neg         (neg),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_cnt counts the cycles left in the busy window; results land when the
  // window reaches its final (done) cycle.
  int           m_cnt;
  logic [W-1:0] m_pend_out, m_out;
  logic         m_pend_b, m_b, m_z, m_n;

  always @(posedge clk or negedge rst) begin
    logic [W:0] diff;
    if (!rst) begin
      m_cnt <= 0;
      m_out <= '0;
      m_b   <= 1'b0;
      m_z   <= 1'b0;
      m_n   <= 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        diff = {1'b0, inp} - 1;
`ifdef DEC_SATURATE_EN
        m_pend_out <= diff[W] ? '0 : diff[W-1:0];
`else
        m_pend_out <= diff[W-1:0];
`endif
        m_pend_b <= diff[W];
        m_cnt    <= N + 1;
      end
    end else begin
      if (m_cnt == 2) begin
        m_out <= m_pend_out;
        m_b   <= m_pend_b;
        m_z   <= (m_pend_out == 0);
        m_n   <= m_pend_out[W-1];
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    chk("cyc_busy", busy, (m_cnt != 0));
    chk("cyc_done", done, (m_cnt == 1));
    chk("cyc_out", out, m_out);
    chk("cyc_borrow", borrow, m_b);
    chk("cyc_zero", zero, m_z);
    chk("cyc_neg", neg, m_n);
  end

  // ---------------- driver tasks ----------------
  task automatic op(input logic [W-1:0] v, input logic [W-1:0] exp_out,
                    input logic eb, input logic ez, input logic en, input string tag);
    int busy_cnt;
    int done_cyc;
    @(negedge clk);
    start = 1'b1;
    inp   = v;
    @(negedge clk);
    start = 1'b0;
    inp   = W'($urandom_range(0, 16'hffff));
    busy_cnt = 0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_done_cycle"}, W'(done_cyc), W'(N + 1));
    chk({tag, "_busy_cycles"}, W'(busy_cnt), W'(N + 1));
    chk({tag, "_out"}, out, exp_out);
    chk({tag, "_borrow"}, borrow, eb);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_neg"}, neg, en);
    @(negedge clk);
    chk({tag, "_idle_after"}, busy, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int done_cnt;
    int k;
    int dc[3];
    logic [W-1:0] ov[3];
    logic zv[3];

    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out", out, 16'h0000);
    chk("rst_flags", {borrow, zero, neg}, 3'b000);
    #3 rst = 1'b1;

    op(16'h000C, 16'h000B, 1'b0, 1'b0, 1'b0, "t1");
    op(16'h1000, 16'h0FFF, 1'b0, 1'b0, 1'b0, "t2");
    op(16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, "t3_one");
    op(16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, "t3_msb");
`ifdef DEC_SATURATE_EN
    op(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, "t3_zero_sat");
`else
    op(16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1, "t3_zero_wrap");
`endif

    // Second start in BUSY cycle 2 must be dropped.
    @(negedge clk); start = 1'b1; inp = 16'h0010;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; inp = 16'h5555;
    @(negedge clk); start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        chk("t4_out", out, 16'h000F);
      end
    end
    chk("t4_done_count", W'(done_cnt), W'(1));
    chk("t4_out_final", out, 16'h000F);

    // Asynchronous reset in BUSY cycle 2.
    @(negedge clk); start = 1'b1; inp = 16'h1234;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_out", out, 16'h0000);
    chk("t5_flags", {borrow, zero, neg}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("t5_no_done", W'(done_cnt), W'(0));
    chk("t5_idle", busy, 1'b0);

    // Start held high: accepted every N+2 cycles.
    @(negedge clk); start = 1'b1; inp = 16'h0003;
    @(negedge clk); inp = 16'h0002;
    k = 0;
    for (int cyc = 1; cyc < 40 && k < 3; cyc++) begin
      if (done) begin
        dc[k] = cyc;
        ov[k] = out;
        zv[k] = zero;
        k++;
        if (k == 2) inp = 16'h0001;
        if (k == 3) start = 1'b0;
      end
      if (k < 3) @(negedge clk);
    end
    start = 1'b0;
    chk("t6_done_count", W'(k), W'(3));
    if (k == 3) begin
      chk("t6_first_done_cycle", W'(dc[0]), W'(N + 1));
      chk("t6_period_a", W'(dc[1] - dc[0]), W'(N + 2));
      chk("t6_period_b", W'(dc[2] - dc[1]), W'(N + 2));
      chk("t6_out0", ov[0], 16'h0002);
      chk("t6_out1", ov[1], 16'h0001);
      chk("t6_out2", ov[2], 16'h0000);
      chk("t6_zero", {zv[0], zv[1], zv[2]}, 3'b001);
    end

    repeat (4) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
